// File: rtl/masked_chi3_inv_pkg.sv
// Shared constants and the two-share state type for the masked chi3 inverse pipeline.
package masked_chi3_inv_pkg;

    localparam int unsigned NumStages  = 3;
    localparam int unsigned StageDepth = 2;
    localparam int unsigned Latency    = NumStages * StageDepth;

    // Bit i of each share holds variable i of the 3-bit state.
    typedef struct packed {
        logic [2:0] s1;
        logic [2:0] s0;
    } shares_t;

endpackage

// File: rtl/masked_toffoli_stage.sv
// Two-level masked Toffoli: state[Target] ^= (~state[BIdx] & state[CIdx]), shares kept apart.
// With CHI3_INV_CLEAR_EN defined, the data registers are cleared by rst.
module masked_toffoli_stage
    import masked_chi3_inv_pkg::*;
#(
    parameter int unsigned Target = 2,
    parameter int unsigned BIdx   = 0,
    parameter int unsigned CIdx   = 1
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_en,
    input  shares_t i_state,
    output shares_t o_state
);

    logic    w_pa0;
    logic    w_pa1;
    shares_t w_next;

    shares_t r_st_a;
    logic    r_pa0;
    logic    r_pa1;
    shares_t r_st_b;

    // Cross terms with c1 first; each partial mixes at most one share of any variable.
    always_comb begin
        w_pa0 = i_state.s0[Target] ^ (~i_state.s0[BIdx] & i_state.s1[CIdx]);
        w_pa1 = i_state.s1[Target] ^ (i_state.s1[BIdx] & i_state.s1[CIdx]);
    end

    // Remaining c0 terms are added only after the register boundary.
    always_comb begin
        w_next            = r_st_a;
        w_next.s0[Target] = r_pa0 ^ (~r_st_a.s0[BIdx] & r_st_a.s0[CIdx]);
        w_next.s1[Target] = r_pa1 ^ (r_st_a.s1[BIdx] & r_st_a.s0[CIdx]);
    end

`ifdef CHI3_INV_CLEAR_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_st_a <= '0;
            r_pa0  <= 1'b0;
            r_pa1  <= 1'b0;
            r_st_b <= '0;
        end else if (i_en) begin
            r_st_a <= i_state;
            r_pa0  <= w_pa0;
            r_pa1  <= w_pa1;
            r_st_b <= w_next;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_st_a <= i_state;
            r_pa0  <= w_pa0;
            r_pa1  <= w_pa1;
            r_st_b <= w_next;
        end
    end

    logic w_unused_rst;
    assign w_unused_rst = i_rst;
`endif

    assign o_state = r_st_b;

endmodule

// File: rtl/masked_chi3_inv.sv
// First-order masked inverse of chi3 as three pipelined Toffoli stages (6-cycle latency).
// Define CHI3_INV_CLEAR_EN to have rst clear the share data registers as well.
module masked_chi3_inv
    import masked_chi3_inv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [2:0] share0_in,
    input  logic [2:0] share1_in,
    output logic       out_valid,
    output logic [2:0] share0_out,
    output logic [2:0] share1_out
);

    shares_t w_st0;
    shares_t w_st1;
    shares_t w_st2;
    shares_t w_st3;

    logic [Latency-1:0] r_valid;

    assign w_st0.s0 = share0_in;
    assign w_st0.s1 = share1_in;

    // x2 = y2 ^ (~y0 & y1)
    masked_toffoli_stage #(.Target(2), .BIdx(0), .CIdx(1)) u_stage0 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_state (w_st0),
        .o_state (w_st1)
    );

    // x1 = y1 ^ (~x2 & y0)
    masked_toffoli_stage #(.Target(1), .BIdx(2), .CIdx(0)) u_stage1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_state (w_st1),
        .o_state (w_st2)
    );

    // x0 = y0 ^ (~x1 & x2)
    masked_toffoli_stage #(.Target(0), .BIdx(1), .CIdx(2)) u_stage2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_state (w_st2),
        .o_state (w_st3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (en) begin
            r_valid <= {r_valid[Latency-2:0], in_valid};
        end
    end

    assign out_valid  = r_valid[Latency-1];
    assign share0_out = w_st3.s0;
    assign share1_out = w_st3.s1;

endmodule
